// File: rtl/mem_ctrl_if.sv
// Client request/response and byte-RAM signals of mem_ctrl, with controller (slave) and
// environment (master) views.
interface mem_ctrl_if #(
  parameter int unsigned MEM_ADD_W = 32,
  parameter int unsigned REG_DAT_W = 32
) ();
  logic                 dc_en;
  logic                 dc_rw;
  logic [2:0]           dc_len;
  logic [MEM_ADD_W-1:0] dc_add;
  logic [REG_DAT_W-1:0] dc_dat;
  logic                 dc_done;
  logic [REG_DAT_W-1:0] dc_rdat;
  logic                 ic_en;
  logic [MEM_ADD_W-1:0] ic_add;
  logic                 ic_done;
  logic [REG_DAT_W-1:0] ic_rdat;
  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;
  logic [MEM_ADD_W-1:0] mem_a;
  logic                 mem_wr;
  logic                 io_full;
  logic                 rob_mp;

  modport slave (
    input  dc_en, dc_rw, dc_len, dc_add, dc_dat, ic_en, ic_add, mem_din, io_full, rob_mp,
    output dc_done, dc_rdat, ic_done, ic_rdat, mem_dout, mem_a, mem_wr
  );

  modport master (
    output dc_en, dc_rw, dc_len, dc_add, dc_dat, ic_en, ic_add, mem_din, io_full, rob_mp,
    input  dc_done, dc_rdat, ic_done, ic_rdat, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates DC (priority) and IC requests and serialises
// each into 8-bit RAM reads/writes, with IO write back-pressure and misprediction flush.
module mem_ctrl #(
  parameter int unsigned          MEM_ADD_W = 32,
  parameter int unsigned          REG_DAT_W = 32,
  parameter logic [MEM_ADD_W-1:0] IO_BASE   = 32'h30000
) (
  input logic       clk,
  input logic       rst,
  input logic       en,
  mem_ctrl_if.slave bus
);
  localparam int unsigned NB = REG_DAT_W / 8;

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d, len_q, len_d;
  logic [MEM_ADD_W-1:0] add_q, add_d;
  logic [REG_DAT_W-1:0] wdat_q, wdat_d, rbuf_q, rbuf_d;
  logic                 is_ic_q, is_ic_d;

  // Pending request slots
  logic                 dcp_v_q, dcp_v_d, dcp_rw_q, dcp_rw_d;
  logic [2:0]           dcp_len_q, dcp_len_d;
  logic [MEM_ADD_W-1:0] dcp_add_q, dcp_add_d;
  logic [REG_DAT_W-1:0] dcp_dat_q, dcp_dat_d;
  logic                 icp_v_q, icp_v_d;
  logic [MEM_ADD_W-1:0] icp_add_q, icp_add_d;

  // Registered outputs
  logic [MEM_ADD_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]           dout_q, dout_d;
  logic                 wr_q, wr_d;
  logic                 dc_done_q, dc_done_d, ic_done_q, ic_done_d;
  logic [REG_DAT_W-1:0] dc_rdat_q, dc_rdat_d, ic_rdat_q, ic_rdat_d;

  logic                 mp, dc_take, ic_take, dc_v_eff, ic_v_eff;
  logic                 dc_s_rw;
  logic [2:0]           dc_s_len;
  logic [MEM_ADD_W-1:0] dc_s_add, ic_s_add;
  logic [REG_DAT_W-1:0] dc_s_dat;
  logic                 grant_dc, grant_ic, step_write;
  logic [MEM_ADD_W-1:0] w_base, w_a;
  logic [REG_DAT_W-1:0] w_dat;
  logic [2:0]           w_idx;
  logic [7:0]           w_byte;

  // A flush only takes effect while enabled; strobes coincident with it are dropped.
  assign mp       = bus.rob_mp & en;
  assign dc_take  = bus.dc_en & ~mp;
  assign ic_take  = bus.ic_en & ~mp;
  assign dc_v_eff = dc_take | (dcp_v_q & ~(mp & ~dcp_rw_q));
  assign ic_v_eff = ic_take | (icp_v_q & ~mp);
  assign dc_s_rw  = dc_take ? bus.dc_rw  : dcp_rw_q;
  assign dc_s_len = dc_take ? bus.dc_len : dcp_len_q;
  assign dc_s_add = dc_take ? bus.dc_add : dcp_add_q;
  assign dc_s_dat = dc_take ? bus.dc_dat : dcp_dat_q;
  assign ic_s_add = ic_take ? bus.ic_add : icp_add_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    add_d      = add_q;
    wdat_d     = wdat_q;
    rbuf_d     = rbuf_q;
    is_ic_d    = is_ic_q;
    mem_a_d    = mem_a_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    dc_done_d  = 1'b0;
    ic_done_d  = 1'b0;
    dc_rdat_d  = dc_rdat_q;
    ic_rdat_d  = ic_rdat_q;
    grant_dc   = 1'b0;
    grant_ic   = 1'b0;
    step_write = 1'b0;
    w_base     = add_q;
    w_dat      = wdat_q;
    w_idx      = cnt_q;
    w_a        = '0;
    w_byte     = '0;

    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (dc_v_eff) begin
            grant_dc = 1'b1;
            is_ic_d  = 1'b0;
            add_d    = dc_s_add;
            len_d    = dc_s_len;
            wdat_d   = dc_s_dat;
            rbuf_d   = '0;
            cnt_d    = '0;
            if (dc_s_rw) begin
              state_d    = StWrite;
              step_write = 1'b1;
              w_base     = dc_s_add;
              w_dat      = dc_s_dat;
              w_idx      = '0;
            end else begin
              state_d = StRead;
              mem_a_d = dc_s_add;
              wr_d    = 1'b0;
            end
          end else if (ic_v_eff) begin
            grant_ic = 1'b1;
            is_ic_d  = 1'b1;
            add_d    = ic_s_add;
            len_d    = 3'd4;
            rbuf_d   = '0;
            cnt_d    = '0;
            state_d  = StRead;
            mem_a_d  = ic_s_add;
            wr_d     = 1'b0;
          end
        end
        StRead: begin
          if (mp) begin
            state_d = StIdle;
          end else begin
            for (int i = 0; i < NB; i++) begin
              if (cnt_q == 3'(i)) rbuf_d[8*i +: 8] = bus.mem_din;
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_d == len_q) begin
              state_d = StIdle;
              if (is_ic_q) begin
                ic_done_d = 1'b1;
                ic_rdat_d = rbuf_d;
              end else begin
                dc_done_d = 1'b1;
                dc_rdat_d = rbuf_d;
              end
            end else begin
              mem_a_d = add_q + MEM_ADD_W'(cnt_d);
            end
          end
        end
        StWrite: begin
          // cnt counts bytes already driven with a write strobe
          if (cnt_q == len_q) begin
            state_d   = StIdle;
            wr_d      = 1'b0;
            dc_done_d = 1'b1;
          end else begin
            step_write = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (step_write) begin
        w_a = w_base + MEM_ADD_W'(w_idx);
        for (int i = 0; i < NB; i++) begin
          if (w_idx == 3'(i)) w_byte = w_dat[8*i +: 8];
        end
        mem_a_d = w_a;
        dout_d  = w_byte;
        if ((w_a >= IO_BASE) && bus.io_full) begin
          wr_d  = 1'b0;
          cnt_d = w_idx;
        end else begin
          wr_d  = 1'b1;
          cnt_d = w_idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    dcp_v_d   = dcp_v_q;
    dcp_rw_d  = dcp_rw_q;
    dcp_len_d = dcp_len_q;
    dcp_add_d = dcp_add_q;
    dcp_dat_d = dcp_dat_q;
    icp_v_d   = icp_v_q;
    icp_add_d = icp_add_q;
    if (dc_take) begin
      dcp_rw_d  = bus.dc_rw;
      dcp_len_d = bus.dc_len;
      dcp_add_d = bus.dc_add;
      dcp_dat_d = bus.dc_dat;
    end
    if (ic_take) icp_add_d = bus.ic_add;
    if (en) begin
      dcp_v_d = dc_v_eff & ~grant_dc;
      icp_v_d = ic_v_eff & ~grant_ic;
    end else begin
      dcp_v_d = dcp_v_q | bus.dc_en;
      icp_v_d = icp_v_q | bus.ic_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      add_q     <= '0;
      wdat_q    <= '0;
      rbuf_q    <= '0;
      is_ic_q   <= 1'b0;
      dcp_v_q   <= 1'b0;
      dcp_rw_q  <= 1'b0;
      dcp_len_q <= '0;
      dcp_add_q <= '0;
      dcp_dat_q <= '0;
      icp_v_q   <= 1'b0;
      icp_add_q <= '0;
      mem_a_q   <= '0;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      dc_done_q <= 1'b0;
      ic_done_q <= 1'b0;
      dc_rdat_q <= '0;
      ic_rdat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      add_q     <= add_d;
      wdat_q    <= wdat_d;
      rbuf_q    <= rbuf_d;
      is_ic_q   <= is_ic_d;
      dcp_v_q   <= dcp_v_d;
      dcp_rw_q  <= dcp_rw_d;
      dcp_len_q <= dcp_len_d;
      dcp_add_q <= dcp_add_d;
      dcp_dat_q <= dcp_dat_d;
      icp_v_q   <= icp_v_d;
      icp_add_q <= icp_add_d;
      mem_a_q   <= mem_a_d;
      dout_q    <= dout_d;
      wr_q      <= wr_d;
      dc_done_q <= dc_done_d;
      ic_done_q <= ic_done_d;
      dc_rdat_q <= dc_rdat_d;
      ic_rdat_q <= ic_rdat_d;
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = dout_q;
  assign bus.mem_wr   = wr_q & en;
  assign bus.dc_done  = dc_done_q;
  assign bus.dc_rdat  = dc_rdat_q;
  assign bus.ic_done  = ic_done_q;
  assign bus.ic_rdat  = ic_rdat_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: combinational byte RAM, write log and done-pulse counters.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   dc_pulses = 0;
  int   ic_pulses = 0;
  int   n;
  int   p0;
  logic [7:0]  ram [0:1023];
  logic [39:0] wlog [$];

  mem_ctrl_if #(.MEM_ADD_W(32), .REG_DAT_W(32)) bus ();

  mem_ctrl #(.MEM_ADD_W(32), .REG_DAT_W(32), .IO_BASE(32'h30000)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_din = ram[bus.mem_a[9:0]];

  always @(negedge clk) begin
    if (bus.mem_wr) wlog.push_back({bus.mem_a, bus.mem_dout});
    if (bus.dc_done) dc_pulses++;
    if (bus.ic_done) ic_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until the selected done pulse is seen or the budget runs out.
  task automatic wait_done(input bit ic, input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(ic ? bus.ic_done : bus.dc_done) && cnt < budget);
  endtask

  task automatic dc_req(input bit rw, input logic [2:0] len, input logic [31:0] add,
                        input logic [31:0] dat);
    bus.dc_en  = 1'b1;
    bus.dc_rw  = rw;
    bus.dc_len = len;
    bus.dc_add = add;
    bus.dc_dat = dat;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h010] = 8'h5A;
    ram[10'h040] = 8'h11; ram[10'h041] = 8'h22; ram[10'h042] = 8'h33; ram[10'h043] = 8'h44;
    ram[10'h080] = 8'h99; ram[10'h081] = 8'h88; ram[10'h082] = 8'h77; ram[10'h083] = 8'h66;
    bus.dc_en = 0; bus.dc_rw = 0; bus.dc_len = 0; bus.dc_add = 0; bus.dc_dat = 0;
    bus.ic_en = 0; bus.ic_add = 0; bus.io_full = 0; bus.rob_mp = 0;

    // Reset state
    tick(); tick();
    chk("rst_dc_done", 64'(bus.dc_done), 64'd0);
    chk("rst_ic_done", 64'(bus.ic_done), 64'd0);
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_mem_a", 64'(bus.mem_a), 64'd0);
    chk("rst_dc_rdat", 64'(bus.dc_rdat), 64'd0);
    rst = 1'b1;
    tick();

    // LW 0x100
    wlog.delete();
    dc_req(1'b0, 3'd4, 32'h100, 32'h0);
    tick();
    bus.dc_en = 1'b0;
    chk("lw_a0", 64'(bus.mem_a), 64'h100);
    chk("lw_wr0", 64'(bus.mem_wr), 64'd0);
    wait_done(1'b0, 10, n);
    chk("lw_done", 64'(bus.dc_done), 64'd1);
    chk("lw_latency", 64'(n), 64'd4);
    chk("lw_data", 64'(bus.dc_rdat), 64'h12345678);
    tick();
    chk("lw_pulse_1cyc", 64'(bus.dc_done), 64'd0);
    chk("lw_hold", 64'(bus.dc_rdat), 64'h12345678);
    chk("lw_no_writes", 64'(wlog.size()), 64'd0);

    // SH 0x202
    dc_req(1'b1, 3'd2, 32'h202, 32'h0000ABCD);
    tick();
    bus.dc_en = 1'b0;
    chk("sh_a0", 64'({bus.mem_a, bus.mem_dout, 7'd0, bus.mem_wr}), {32'h202, 8'hCD, 8'h01});
    tick();
    chk("sh_a1", 64'({bus.mem_a, bus.mem_dout, 7'd0, bus.mem_wr}), {32'h203, 8'hAB, 8'h01});
    tick();
    chk("sh_done", 64'(bus.dc_done), 64'd1);
    chk("sh_wr_off", 64'(bus.mem_wr), 64'd0);
    chk("sh_nwrites", 64'(wlog.size()), 64'd2);

    // DC LB and IC fetch on the same edge
    p0 = ic_pulses;
    dc_req(1'b0, 3'd1, 32'h10, 32'h0);
    bus.ic_en = 1'b1; bus.ic_add = 32'h40;
    tick();
    bus.dc_en = 1'b0; bus.ic_en = 1'b0;
    chk("arb_dc_first", 64'(bus.mem_a), 64'h10);
    wait_done(1'b0, 10, n);
    chk("arb_lb_lat", 64'(n), 64'd1);
    chk("arb_lb_data", 64'(bus.dc_rdat), 64'h5A);
    wait_done(1'b1, 12, n);
    chk("arb_ic_lat", 64'(n), 64'd5);
    chk("arb_ic_data", 64'(bus.ic_rdat), 64'h44332211);
    p0 = dc_pulses;
    tick(); tick(); tick();
    chk("arb_no_extra_dc", 64'(dc_pulses), 64'(p0));

    // SB to IO with back-pressure for three cycles
    wlog.delete();
    dc_req(1'b1, 3'd1, 32'h30000, 32'h123456A7);
    bus.io_full = 1'b1;
    tick();
    bus.dc_en = 1'b0;
    chk("io_full0", 64'({bus.mem_a, 7'd0, bus.mem_wr}), {32'h30000, 8'h00});
    tick();
    chk("io_full1", 64'(bus.mem_wr), 64'd0);
    tick();
    chk("io_full2", 64'(bus.mem_wr), 64'd0);
    bus.io_full = 1'b0;
    tick();
    chk("io_write", 64'({bus.mem_a, bus.mem_dout, 7'd0, bus.mem_wr}), {32'h30000, 8'hA7, 8'h01});
    tick();
    chk("io_done", 64'(bus.dc_done), 64'd1);
    chk("io_nwrites", 64'(wlog.size()), 64'd1);

    // IC fetch flushed at byte 2 while a SW waits
    wlog.delete();
    p0 = ic_pulses;
    bus.ic_en = 1'b1; bus.ic_add = 32'h80;
    tick();
    bus.ic_en = 1'b0;
    dc_req(1'b1, 3'd4, 32'h300, 32'hDEADBEEF);
    tick();
    bus.dc_en = 1'b0;
    tick();
    chk("mp_a2", 64'(bus.mem_a), 64'h82);
    bus.rob_mp = 1'b1;
    tick();
    bus.rob_mp = 1'b0;
    chk("mp_wr_off", 64'(bus.mem_wr), 64'd0);
    wait_done(1'b0, 12, n);
    chk("mp_sw_done", 64'(bus.dc_done), 64'd1);
    chk("mp_sw_lat", 64'(n), 64'd5);
    chk("mp_no_ic_done", 64'(ic_pulses), 64'(p0));
    chk("mp_nwrites", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) begin
      chk("mp_w0", 64'(wlog[0]), 64'({32'h300, 8'hEF}));
      chk("mp_w3", 64'(wlog[3]), 64'({32'h303, 8'hDE}));
    end

    // Fetch strobe coincident with flush is ignored
    p0 = ic_pulses;
    bus.ic_en = 1'b1; bus.ic_add = 32'h40; bus.rob_mp = 1'b1;
    tick();
    bus.ic_en = 1'b0; bus.rob_mp = 1'b0;
    repeat (8) tick();
    chk("mp_strobe_drop", 64'(ic_pulses), 64'(p0));

    // en=0 freezes but still latches the strobe
    en = 1'b0;
    dc_req(1'b0, 3'd1, 32'h10, 32'h0);
    tick();
    bus.dc_en = 1'b0;
    tick(); tick();
    chk("en_freeze", 64'(bus.dc_done), 64'd0);
    en = 1'b1;
    wait_done(1'b0, 8, n);
    chk("en_lat", 64'(n), 64'd2);
    chk("en_data", 64'(bus.dc_rdat), 64'h5A);

    // Reset mid-SW, then a fresh LW
    dc_req(1'b1, 3'd4, 32'h310, 32'h01020304);
    tick();
    bus.dc_en = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_mid_a", 64'(bus.mem_a), 64'd0);
    chk("rst_mid_rdat", 64'(bus.dc_rdat), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    dc_req(1'b0, 3'd4, 32'h100, 32'h0);
    tick();
    bus.dc_en = 1'b0;
    wait_done(1'b0, 10, n);
    chk("post_rst_lat", 64'(n), 64'd4);
    chk("post_rst_data", 64'(bus.dc_rdat), 64'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
